// File: rtl/player_input_decoder_pkg.sv
// Shared scan-code constants, keycode/state enumerations and key-mapping helpers
// for the player input decoder.
package player_input_decoder_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [1:0] GS_PLAY = 2'b01;

    localparam int HELD_W    = 5;
    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_SPACE = 4;

    typedef enum logic [3:0] {
        KC_NONE = 4'd0,
        KC_W    = 4'd1,
        KC_A    = 4'd2,
        KC_S    = 4'd3,
        KC_D    = 4'd4,
        KC_WA   = 4'd5,
        KC_WD   = 4'd6,
        KC_SA   = 4'd7,
        KC_SD   = 4'd8
    } keycode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } scan_state_e;

    // One-hot held-key bit for a tracked scan code; zero for anything else.
    function automatic logic [HELD_W-1:0] key_onehot(input logic [7:0] sc);
        logic [HELD_W-1:0] hit;
        hit = '0;
        case (sc)
            SC_W:     hit[KEY_W]     = 1'b1;
            SC_A:     hit[KEY_A]     = 1'b1;
            SC_S:     hit[KEY_S]     = 1'b1;
            SC_D:     hit[KEY_D]     = 1'b1;
            SC_SPACE: hit[KEY_SPACE] = 1'b1;
            default:  hit = '0;
        endcase
        return hit;
    endfunction

    // Opposing keys cancel on each axis before the axes are combined.
    function automatic keycode_e direction_code(input logic [HELD_W-1:0] held);
        logic up, down, left, right;
        keycode_e kc;
        up    = held[KEY_W] & ~held[KEY_S];
        down  = held[KEY_S] & ~held[KEY_W];
        left  = held[KEY_A] & ~held[KEY_D];
        right = held[KEY_D] & ~held[KEY_A];
        kc = KC_NONE;
        if (up && left)        kc = KC_WA;
        else if (up && right)  kc = KC_WD;
        else if (down && left) kc = KC_SA;
        else if (down && right) kc = KC_SD;
        else if (up)           kc = KC_W;
        else if (down)         kc = KC_S;
        else if (left)         kc = KC_A;
        else if (right)        kc = KC_D;
        return kc;
    endfunction

endpackage

// File: rtl/ps2_scancode_fsm.sv
// PS/2 set-2 byte sequencer: turns prefixed byte streams into make/break strobes.
//   state   | meaning
//   IDLE    | expecting a make code or a prefix byte
//   BRK     | F0 seen, next byte is a break code
//   EXT     | E0 seen, extended sequence in progress
//   EXT_BRK | E0 F0 seen, next byte ends the extended break
module ps2_scancode_fsm
    import player_input_decoder_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       scanValid,
    input  logic [7:0] scanCode,
    output logic       makeStrobe,
    output logic       breakStrobe,
    output logic [7:0] code
);

    scan_state_e state, state_next;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Strobes are combinational so the held-key register lands one Clk after the byte.
    always_comb begin
        state_next  = state;
        makeStrobe  = 1'b0;
        breakStrobe = 1'b0;
        if (scanValid) begin
            case (state)
                IDLE: begin
                    if (scanCode == SC_BREAK)    state_next = BRK;
                    else if (scanCode == SC_EXT) state_next = EXT;
                    else                         makeStrobe = 1'b1;
                end
                BRK: begin
                    breakStrobe = 1'b1;
                    state_next  = IDLE;
                end
                EXT: begin
                    if (scanCode == SC_BREAK) state_next = EXT_BRK;
                    else                      state_next = IDLE;
                end
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign code = scanCode;

endmodule

// File: rtl/player_input_decoder.sv
// Keyboard-to-game decoder: tracks held WASD/Space keys, produces a registered
// direction code and a one-frame jump request aligned to VS.
module player_input_decoder
    import player_input_decoder_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       scanValid,
    input  logic [7:0] scanCode,
    input  logic       VS,
    input  logic [1:0] gameState,
    output logic [3:0] keycode,
    output logic       keyPress,
    output logic       Jumping
);

    logic              make_strobe;
    logic              break_strobe;
    logic [7:0]        code;
    logic [HELD_W-1:0] held;
    logic [HELD_W-1:0] key_hit;
    logic              vs_q;
    logic              vs_rise;
    logic              play;
    logic              space_press;
    logic              jump_pending;
    keycode_e          keycode_q;
    logic              key_press_q;

    ps2_scancode_fsm u_scan_fsm (
        .Clk         (Clk),
        .Reset       (Reset),
        .scanValid   (scanValid),
        .scanCode    (scanCode),
        .makeStrobe  (make_strobe),
        .breakStrobe (break_strobe),
        .code        (code)
    );

    assign key_hit     = key_onehot(code);
    assign play        = (gameState == GS_PLAY);
    assign vs_rise     = VS & ~vs_q;
    // Typematic repeats arrive as makes while Space is already held; only a fresh press jumps.
    assign space_press = make_strobe && (code == SC_SPACE) && !held[KEY_SPACE];

    // Held keys keep tracking outside play so outputs are correct on return.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            held <= '0;
        end else if (make_strobe) begin
            held <= held | key_hit;
        end else if (break_strobe) begin
            held <= held & ~key_hit;
        end
    end

    // A new press wins over a same-cycle VS edge so the jump survives to the next frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vs_q         <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            vs_q <= VS;
            if (!play)            jump_pending <= 1'b0;
            else if (space_press) jump_pending <= 1'b1;
            else if (vs_rise)     jump_pending <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            keycode_q   <= KC_NONE;
            key_press_q <= 1'b0;
        end else if (play) begin
            keycode_q   <= direction_code(held);
            key_press_q <= |held;
        end else begin
            keycode_q   <= KC_NONE;
            key_press_q <= 1'b0;
        end
    end

    assign keycode  = keycode_q;
    assign keyPress = key_press_q;
    // Gated by play so Jumping drops in the same cycle play is left.
    assign Jumping  = jump_pending & play;

endmodule
